// File: rtl/segment_decode_monitor_if.sv
// Bus between a segment-pattern source and the segment decode monitor.
// Optional error-count line exists only when SEG_DECODE_ERR_COUNT_EN is defined.
interface segment_decode_monitor_if;
  logic       i_Enable;
  logic [6:0] i_Segment;
  logic [3:0] o_Digit;
  logic       o_Valid;
  logic       o_Blank;
  logic       o_Error;
  logic       o_Strobe;
`ifdef SEG_DECODE_ERR_COUNT_EN
  logic [7:0] o_Error_Count;
`endif

  modport master (
    output i_Enable,
    output i_Segment,
    input  o_Digit,
    input  o_Valid,
    input  o_Blank,
    input  o_Error,
`ifdef SEG_DECODE_ERR_COUNT_EN
    input  o_Error_Count,
`endif
    input  o_Strobe
  );

  modport slave (
    input  i_Enable,
    input  i_Segment,
    output o_Digit,
    output o_Valid,
    output o_Blank,
    output o_Error,
`ifdef SEG_DECODE_ERR_COUNT_EN
    output o_Error_Count,
`endif
    output o_Strobe
  );
endinterface

// File: rtl/segment_decode_monitor.sv
// Recovers a 0-9 digit from an active-low 7-segment pattern once it has held steady.
// Define SEG_DECODE_ERR_COUNT_EN to add a saturating count of illegal commits.
`timescale 1ns/1ps
module segment_decode_monitor #(
  parameter int unsigned STABLE_CYCLES = 16
) (
  input logic                     i_Clk,
  input logic                     i_Reset,
  segment_decode_monitor_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETTLE, LOCKED} state_t;

  localparam logic [7:0] LAST_COUNT = 8'(STABLE_CYCLES - 1);

  state_t     r_State, w_NextState;
  logic [6:0] r_Seg, r_Cand;
  logic [7:0] r_Count;
  logic [3:0] r_Digit;
  logic       r_Valid, r_Blank, r_Error, r_Strobe;
  logic       w_LoadCand, w_ClearCount, w_IncCount, w_Commit;
  logic [3:0] w_DecDigit;
  logic       w_DecLegal, w_DecBlank, w_Differs;

  always_comb begin
    w_DecDigit = 4'd0;
    w_DecLegal = 1'b1;
    w_DecBlank = 1'b0;
    case (r_Seg)
      7'b1000000: w_DecDigit = 4'd0;
      7'b1111001: w_DecDigit = 4'd1;
      7'b0100100: w_DecDigit = 4'd2;
      7'b0110000: w_DecDigit = 4'd3;
      7'b0011001: w_DecDigit = 4'd4;
      7'b0010010: w_DecDigit = 4'd5;
      7'b0000010: w_DecDigit = 4'd6;
      7'b1111000: w_DecDigit = 4'd7;
      7'b0000000: w_DecDigit = 4'd8;
      7'b0010000: w_DecDigit = 4'd9;
      7'b1111111: begin
        w_DecLegal = 1'b0;
        w_DecBlank = 1'b1;
      end
      default:    w_DecLegal = 1'b0;
    endcase
  end

  // No class flag set means nothing has committed since reset, so the first commit always strobes.
  assign w_Differs = !(r_Valid || r_Blank || r_Error) ||
                     (w_DecLegal != r_Valid) || (w_DecBlank != r_Blank) ||
                     (w_DecLegal && (w_DecDigit != r_Digit));

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) r_State <= IDLE;
    else         r_State <= w_NextState;
  end

  always_comb begin
    w_NextState  = r_State;
    w_LoadCand   = 1'b0;
    w_ClearCount = 1'b0;
    w_IncCount   = 1'b0;
    w_Commit     = 1'b0;
    if (!bus.i_Enable) begin
      w_NextState  = IDLE;
      w_ClearCount = 1'b1;
    end else begin
      case (r_State)
        IDLE: begin
          w_LoadCand   = 1'b1;
          w_ClearCount = 1'b1;
          w_NextState  = SETTLE;
        end
        SETTLE: begin
          if (r_Seg != r_Cand) begin
            w_LoadCand   = 1'b1;
            w_ClearCount = 1'b1;
          end else if (r_Count == LAST_COUNT) begin
            w_Commit     = 1'b1;
            w_ClearCount = 1'b1;
            w_NextState  = LOCKED;
          end else begin
            w_IncCount = 1'b1;
          end
        end
        LOCKED: begin
          if (r_Seg != r_Cand) begin
            w_LoadCand   = 1'b1;
            w_ClearCount = 1'b1;
            w_NextState  = SETTLE;
          end
        end
        default: w_NextState = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_Seg   <= 7'h7F;
      r_Cand  <= 7'h7F;
      r_Count <= 8'd0;
    end else begin
      r_Seg <= bus.i_Segment;
      if (w_LoadCand) r_Cand <= r_Seg;
      if (w_ClearCount)    r_Count <= 8'd0;
      else if (w_IncCount) r_Count <= r_Count + 8'd1;
    end
  end

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_Digit  <= 4'd0;
      r_Valid  <= 1'b0;
      r_Blank  <= 1'b0;
      r_Error  <= 1'b0;
      r_Strobe <= 1'b0;
    end else begin
      r_Strobe <= 1'b0;
      if (w_Commit) begin
        r_Valid  <= w_DecLegal;
        r_Blank  <= w_DecBlank;
        r_Error  <= !w_DecLegal && !w_DecBlank;
        r_Strobe <= w_Differs;
        if (w_DecLegal) r_Digit <= w_DecDigit;
      end
    end
  end

  assign bus.o_Digit  = r_Digit;
  assign bus.o_Valid  = r_Valid;
  assign bus.o_Blank  = r_Blank;
  assign bus.o_Error  = r_Error;
  assign bus.o_Strobe = r_Strobe;

`ifdef SEG_DECODE_ERR_COUNT_EN
  logic [7:0] r_ErrCount;

  always_ff @(posedge i_Clk or posedge i_Reset) begin
    if (i_Reset) begin
      r_ErrCount <= 8'd0;
    end else if (w_Commit && !w_DecLegal && !w_DecBlank && (r_ErrCount != 8'hFF)) begin
      r_ErrCount <= r_ErrCount + 8'd1;
    end
  end

  assign bus.o_Error_Count = r_ErrCount;
`endif

endmodule
